// File: rtl/remote_comm_pkg.sv
// Shared definitions for the remote command link.
//   BYTE_W      : width of one serial byte
//   rc_state_t  : sequencer states of remote_comm_mb
package remote_comm_pkg;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TX_LOAD = 2'd1,
    TX_WAIT = 2'd2,
    RX_WAIT = 2'd3
  } rc_state_t;
endpackage

// File: rtl/UART.sv
// 8N1 UART transceiver, BAUD_DIV clk cycles per bit.
//   clk, rst_n        : clock, async active-low reset
//   RX / TX           : serial in / out (TX idles high)
//   trmt, tx_data     : start transmitting tx_data (ignored while a frame is in flight)
//   tx_done           : one-cycle pulse at the end of the stop bit
//   rx_rdy, rx_data   : received byte valid (level) and its value
//   clr_rx_rdy        : acknowledge, drops rx_rdy
module UART #(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  output logic       TX,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       tx_done,
  output logic       rx_rdy,
  input  logic       clr_rx_rdy,
  output logic [7:0] rx_data
);
  localparam int BW = $clog2(BAUD_DIV + 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] BAUD_HALF = BW'(BAUD_DIV / 2);

  // transmitter: {stop, data, start} shifted out LSB first
  logic [9:0]    tx_sr;
  logic [3:0]    tx_bits;
  logic [BW-1:0] tx_baud;
  logic          tx_busy;

  assign TX = tx_sr[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_sr   <= '1;
      tx_bits <= '0;
      tx_baud <= '0;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (!tx_busy) begin
        if (trmt) begin
          tx_sr   <= {1'b1, tx_data, 1'b0};
          tx_bits <= '0;
          tx_baud <= '0;
          tx_busy <= 1'b1;
        end
      end else if (tx_baud == BAUD_LAST) begin
        tx_baud <= '0;
        tx_sr   <= {1'b1, tx_sr[9:1]};
        if (tx_bits == 4'd9) begin
          tx_busy <= 1'b0;
          tx_done <= 1'b1;
        end else begin
          tx_bits <= tx_bits + 4'd1;
        end
      end else begin
        tx_baud <= tx_baud + 1'b1;
      end
    end
  end

  // receiver: samples mid-bit; the start bit is shifted through and out
  logic          rx_ff1, rx_s;
  logic [7:0]    rx_sr;
  logic [3:0]    rx_bits;
  logic [BW-1:0] rx_cnt;
  logic          rx_busy;

  assign rx_data = rx_sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ff1  <= 1'b1;
      rx_s    <= 1'b1;
      rx_sr   <= '0;
      rx_bits <= '0;
      rx_cnt  <= '0;
      rx_busy <= 1'b0;
      rx_rdy  <= 1'b0;
    end else begin
      rx_ff1 <= RX;
      rx_s   <= rx_ff1;
      if (clr_rx_rdy) rx_rdy <= 1'b0;
      if (!rx_busy) begin
        if (!rx_s) begin
          rx_busy <= 1'b1;
          rx_bits <= '0;
          rx_cnt  <= BAUD_HALF;
          rx_rdy  <= 1'b0;
        end
      end else if (rx_cnt == '0) begin
        rx_cnt <= BAUD_LAST;
        if (rx_bits == 4'd9) begin
          rx_busy <= 1'b0;
          rx_rdy  <= 1'b1;
        end else begin
          rx_sr   <= {rx_s, rx_sr[7:1]};
          rx_bits <= rx_bits + 4'd1;
        end
      end else begin
        rx_cnt <= rx_cnt - 1'b1;
      end
    end
  end
endmodule

// File: rtl/remote_comm_mb.sv
// Host-side multi-byte command/response sequencer over an 8-bit UART.
// Sends CMD_BYTES command bytes MSB first, then gathers RESP_BYTES reply
// bytes (first byte lands in the MSB) with a TIMEOUT_CYC response window.
//   clk, rst_n : clock, async active-low reset
//   RX / TX    : serial from / to the remote device
//   cmd        : command word, captured on an accepted send_cmd
//   send_cmd   : start pulse, ignored while busy
//   cmd_sent   : last command byte has left the UART
//   resp       : assembled response; resp_rdy: all bytes in
//   timeout    : response window expired; busy: transaction in progress
module remote_comm_mb
  import remote_comm_pkg::*;
#(
  parameter int CMD_BYTES   = 2,
  parameter int RESP_BYTES  = 1,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int BAUD_DIV    = 2604
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       RX,
  output logic                       TX,
  input  logic [BYTE_W*CMD_BYTES-1:0]  cmd,
  input  logic                       send_cmd,
  output logic                       cmd_sent,
  output logic [BYTE_W*RESP_BYTES-1:0] resp,
  output logic                       resp_rdy,
  output logic                       timeout,
  output logic                       busy
);
  localparam int CMD_W  = BYTE_W * CMD_BYTES;
  localparam int RESP_W = BYTE_W * RESP_BYTES;
  localparam int TXC_W  = $clog2(CMD_BYTES + 1);
  localparam int RXC_W  = $clog2(RESP_BYTES + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYC);
  localparam logic [TXC_W-1:0] TX_LAST = TXC_W'(CMD_BYTES - 1);
  localparam logic [RXC_W-1:0] RX_LAST = RXC_W'(RESP_BYTES - 1);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  rc_state_t          state;
  logic [CMD_W-1:0]   tx_sr;
  logic [TXC_W-1:0]   tx_cnt;
  logic [RXC_W-1:0]   rx_cnt;
  logic [TO_W-1:0]    to_cnt;
  logic               trmt, tx_done, rx_rdy, clr_rx_rdy;
  logic [BYTE_W-1:0]  tx_data, rx_data;
  logic               rx_last, expired;

  assign trmt    = (state == TX_LOAD);
  assign tx_data = tx_sr[CMD_W-1 -: BYTE_W];
  // every received byte is acknowledged at once: consumed in RX_WAIT,
  // discarded in any other state
  assign clr_rx_rdy = rx_rdy;
  assign rx_last    = rx_rdy && (rx_cnt == RX_LAST);
  assign expired    = (to_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tx_sr    <= '0;
      tx_cnt   <= '0;
      rx_cnt   <= '0;
      to_cnt   <= '0;
      cmd_sent <= 1'b0;
      resp     <= '0;
      resp_rdy <= 1'b0;
      timeout  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (send_cmd) begin
          tx_sr    <= cmd;
          tx_cnt   <= '0;
          cmd_sent <= 1'b0;
          resp_rdy <= 1'b0;
          timeout  <= 1'b0;
          busy     <= 1'b1;
          state    <= TX_LOAD;
        end
        TX_LOAD: state <= TX_WAIT;
        TX_WAIT: if (tx_done) begin
          tx_sr  <= tx_sr << BYTE_W;
          tx_cnt <= tx_cnt + 1'b1;
          if (tx_cnt == TX_LAST) begin
            cmd_sent <= 1'b1;
            to_cnt   <= '0;
            rx_cnt   <= '0;
            state    <= RX_WAIT;
          end else begin
            state <= TX_LOAD;
          end
        end
        RX_WAIT: begin
          if (rx_rdy) begin
            resp   <= RESP_W'({resp, rx_data});
            rx_cnt <= rx_cnt + 1'b1;
          end
          // completion takes priority over a same-cycle expiry
          if (rx_last) begin
            resp_rdy <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end else if (expired) begin
            timeout <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  UART #(.BAUD_DIV(BAUD_DIV)) u_uart (
    .clk       (clk),
    .rst_n     (rst_n),
    .RX        (RX),
    .TX        (TX),
    .trmt      (trmt),
    .tx_data   (tx_data),
    .tx_done   (tx_done),
    .rx_rdy    (rx_rdy),
    .clr_rx_rdy(clr_rx_rdy),
    .rx_data   (rx_data)
  );
endmodule

// File: doc/remote_comm_mb.md
Name: remote_comm_mb

Overview:
- Parametrised successor of the single-command remote link: transmits a CMD_BYTES-wide command over the existing 8-bit UART, MSB byte first.
- Collects a RESP_BYTES-wide response, first received byte into the MSB.
- Adds a response timeout and a busy indicator.
- Sits on the host side of the serial link, driving the DUT's RX and receiving from the DUT's TX.

Parameters:
- CMD_BYTES, 2, number of command bytes sent per transaction (>=1).
- RESP_BYTES, 1, number of response bytes expected per transaction (>=1).
- TIMEOUT_CYC, 1000000, clk cycles allowed from cmd_sent to final response byte before abort (>=2).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- RX  in  1  serial input from DUT
- TX  out  1  serial output to DUT
- cmd  in  8*CMD_BYTES  command word, sampled only on accepted send_cmd
- send_cmd  in  1  single-cycle request to start a transaction
- cmd_sent  out  1  level; last command byte finished shifting out
- resp  out  8*RESP_BYTES  assembled response, stable while resp_rdy=1
- resp_rdy  out  1  level; all RESP_BYTES received
- timeout  out  1  level; response not completed within TIMEOUT_CYC
- busy  out  1  high from accepted send_cmd until return to IDLE

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk.
- Reset values: state=IDLE; cmd_sent=0; resp_rdy=0; timeout=0; busy=0; resp=0; byte counters=0; timeout counter=0; trmt=0.
- States: IDLE, TX_LOAD, TX_WAIT, RX_WAIT.
- IDLE: send_cmd=1 at edge N is accepted.
  - cmd is captured into the tx shift register.
  - cmd_sent, resp_rdy and timeout are cleared; busy is set; tx byte count=0.
  - Next state is TX_LOAD.
- TX_LOAD (one cycle): trmt=1 with tx_data=shift_reg[8*CMD_BYTES-1 -: 8]; go to TX_WAIT. First trmt therefore occurs in cycle N+1.
- TX_WAIT: on tx_done, shift the register left by 8 and increment the byte count.
  - If count reaches CMD_BYTES: set cmd_sent, clear the timeout counter and rx byte count, go to RX_WAIT.
  - Otherwise go to TX_LOAD. Each subsequent trmt is exactly 1 cycle after the prior tx_done.
- RX_WAIT: the timeout counter increments every cycle.
  - On UART rx_rdy: resp <= {resp[8*RESP_BYTES-9:0], rx_data}, or resp <= rx_data when RESP_BYTES=1. Pulse clr_rx_rdy for 1 cycle and increment the rx count.
  - On the RESP_BYTES-th byte: resp_rdy=1 the next cycle, busy=0, go to IDLE.
- Timeout: if the counter reaches TIMEOUT_CYC-1 without completion, set timeout=1 and busy=0, go to IDLE. resp holds the partial bytes and resp_rdy stays 0. A byte arriving in the same cycle as expiry is accepted (completion wins).
- RX bytes received in IDLE, TX_LOAD or TX_WAIT are discarded via a clr_rx_rdy pulse and do not count toward the response.
- send_cmd while busy=1 is ignored: no capture, no flag changes.
- send_cmd in IDLE in the same cycle that resp_rdy/timeout would be read is accepted; the flags clear on that edge.
- cmd_sent remains high through RX_WAIT and IDLE until the next accepted send_cmd.
- Reset mid-transaction returns to IDLE immediately. The UART is reset by the same rst_n, so any partial frame on TX is aborted and TX returns to idle-high per UART.
- Counters are sized $clog2(N+1); the timeout counter is $clog2(TIMEOUT_CYC) bits wide and saturates at expiry.

Decomposition:
- Shared package remote_comm_pkg: state enum type rc_state_t {IDLE, TX_LOAD, TX_WAIT, RX_WAIT}; localparam BYTE_W=8.
- Sub-module: instantiate the existing UART transceiver (UART) unchanged. All sequencing, shift registers and the timeout counter live in remote_comm_mb.
- Natural split: an optional rc_byte_shifter sub-module for the parametrised load/shift register, used for both TX and RX.

Test Plan:
- CMD_BYTES=3, RESP_BYTES=1: send_cmd with cmd=24'hA5_3C_0F, DUT-side UART model echoes 8'hA5 -> TX frames A5,3C,0F in order; cmd_sent rises after third tx_done; resp=8'hA5, resp_rdy=1, busy=0.
- CMD_BYTES=2, RESP_BYTES=2: cmd=16'h1234, model replies 8'hBE then 8'hEF -> resp=16'hBEEF; resp_rdy rises 1 cycle after the second byte's rx_rdy.
- TIMEOUT_CYC=500, no reply -> timeout=1 exactly 500 cycles after cmd_sent; resp_rdy=0; busy=0; next send_cmd clears timeout and cmd_sent.
- send_cmd pulsed again mid-TX with cmd=16'hFFFF -> ignored; transmitted bytes remain those of the first cmd.
- Stray byte 8'h77 injected on RX while in TX_WAIT -> discarded; following reply 8'h55 yields resp=8'h55.
- Assert rst_n=0 during the second TX byte -> all outputs return to reset values asynchronously; TX idles high; a fresh transaction afterwards completes normally.
